// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the 16-bit core: word-addressed synchronous RAM
// with configurable wait states, stalling the core until each load/store completes.
module data_mem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        bus_err
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("data_mem_ctrl: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        req, capture, commit, in_range;
  logic        cap_write, cap_both;
  logic [15:0] cap_addr, cap_wdata;
  logic        acc_write, acc_both;
  logic [15:0] acc_addr, acc_wdata;
  logic [15:0] mem [DEPTH];

  assign req   = ram_read | ram_write;
  assign stall = ((state == S_IDLE) && req) || (state == S_WAIT);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the capture edge, so the access
  // operands bypass the capture registers while still in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      acc_write = ram_write;
      acc_both  = ram_read & ram_write;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_write = cap_write;
      acc_both  = cap_both;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end
  end

  assign commit   = (state_next == S_RESP) && !rst;
  assign in_range = {1'b0, acc_addr} < DEPTH_W;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_both  <= 1'b0;
      cap_addr  <= 16'h0000;
      cap_wdata <= 16'h0000;
    end else if (capture) begin
      cap_write <= ram_write;
      cap_both  <= ram_read & ram_write;
      cap_addr  <= addr;
      cap_wdata <= wdata;
    end
  end

  // rdata only moves on a completed read; an errored read returns zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata   <= 16'h0000;
      done    <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      done    <= commit;
      bus_err <= commit && (!in_range || acc_both);
      if (commit && !acc_write) begin
        rdata <= in_range ? mem[acc_addr[AW-1:0]] : 16'h0000;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst and stay undefined
  // until written, which lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (commit && acc_write && in_range) begin
      mem[acc_addr[AW-1:0]] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: three instances (WAIT_CYCLES 1, 0, 3)
// driven by a directed vector table, reset-abort sequences and random accesses.
module tb_data_mem_ctrl;

  localparam int N_DUT = 3;

  function automatic int wc_of(int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N_DUT];
  logic        ram_read  [N_DUT];
  logic        ram_write [N_DUT];
  logic [15:0] addr      [N_DUT];
  logic [15:0] wdata     [N_DUT];
  logic [15:0] rdata     [N_DUT];
  logic        stall     [N_DUT];
  logic        done      [N_DUT];
  logic        bus_err   [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    data_mem_ctrl #(
      .DEPTH      (256),
      .WAIT_CYCLES(wc_of(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .ram_read (ram_read[g]),
      .ram_write(ram_write[g]),
      .addr     (addr[g]),
      .wdata    (wdata[g]),
      .rdata    (rdata[g]),
      .stall    (stall[g]),
      .done     (done[g]),
      .bus_err  (bus_err[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: plain memory array plus the last value a read returned.
  logic [15:0] ref_mem   [N_DUT][256];
  logic [15:0] ref_rdata [N_DUT];

  function automatic void model(int i, bit rd, bit wr, logic [15:0] a, logic [15:0] d,
                                output bit err, output logic [15:0] rdv);
    bit oor;
    oor = (a >= 16'd256);
    err = oor || (rd && wr);
    if (wr) begin
      if (!oor) ref_mem[i][a[7:0]] = d;
      rdv = ref_rdata[i];
    end else begin
      rdv = oor ? 16'h0000 : ref_mem[i][a[7:0]];
    end
  endfunction

  task automatic drive_idle(int i);
    ram_read[i]  = 1'b0;
    ram_write[i] = 1'b0;
    addr[i]      = 16'h0000;
    wdata[i]     = 16'h0000;
  endtask

  // Issue one access held until done; called and returns at posedge+1.
  task automatic access(int i, bit rd, bit wr, logic [15:0] a, logic [15:0] d,
                        bit scramble, bit exp_err, logic [15:0] exp_rd, string tag);
    int  k;
    bit  seen;
    seen         = 1'b0;
    ram_read[i]  = rd;
    ram_write[i] = wr;
    addr[i]      = a;
    wdata[i]     = d;
    for (k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, " rdata_hold"}, rdata[i], ref_rdata[i]);
      if (done[i] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check({tag, " busy{stall,done,err}"}, {stall[i], done[i], bus_err[i]}, 3'b100);
      @(posedge clk); #1;
      if (scramble) begin
        ram_read[i]  = 1'($urandom_range(0, 1));
        ram_write[i] = 1'($urandom_range(0, 1));
        addr[i]      = 16'($urandom);
        wdata[i]     = 16'($urandom);
      end
    end
    if (!seen) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " latency"}, k, wc_of(i) + 1);
      check({tag, " {stall,bus_err}"}, {stall[i], bus_err[i]}, {1'b0, exp_err});
      check({tag, " rdata"}, rdata[i], exp_rd);
      @(posedge clk); #1;
    end
    ref_rdata[i] = exp_rd;
    drive_idle(i);
  endtask

  // Start a write, then pulse rst at the start of cycle rst_cycle.
  task automatic reset_abort(int i, logic [15:0] a, logic [15:0] d, int rst_cycle, string tag);
    int n_done;
    n_done       = 0;
    ram_write[i] = 1'b1;
    addr[i]      = a;
    wdata[i]     = d;
    @(negedge clk);
    check({tag, " stall_before"}, stall[i], 1'b1);
    repeat (rst_cycle) @(posedge clk);
    #1 rst[i] = 1'b1;
    @(posedge clk); #1;
    rst[i] = 1'b0;
    drive_idle(i);
    @(negedge clk);
    check({tag, " after_rst{stall,done,err}"}, {stall[i], done[i], bus_err[i]}, 3'b000);
    check({tag, " after_rst rdata"}, rdata[i], 16'h0000);
    ref_rdata[i] = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done[i] === 1'b1) n_done++;
    end
    check({tag, " no_done"}, n_done, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          inst;
    bit          rd;
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    bit          err;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          e;
    logic [15:0] r;

    vecs[0]  = '{0, 1'b0, 1'b1, 16'h0000, 16'h0042, 1'b0, 16'h0000};
    vecs[1]  = '{0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[2]  = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vecs[3]  = '{0, 1'b0, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 16'hBEEF};
    vecs[4]  = '{0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0042};
    vecs[5]  = '{0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000};
    vecs[6]  = '{0, 1'b1, 1'b1, 16'h0020, 16'h5A5A, 1'b1, 16'h0000};
    vecs[7]  = '{0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h5A5A};
    vecs[8]  = '{0, 1'b0, 1'b1, 16'h0003, 16'h0001, 1'b0, 16'h5A5A};
    vecs[9]  = '{0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0001};
    vecs[10] = '{0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000};
    vecs[11] = '{0, 1'b0, 1'b1, 16'h00FF, 16'hCAFE, 1'b0, 16'h0000};
    vecs[12] = '{0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'hCAFE};
    vecs[13] = '{1, 1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000};
    vecs[14] = '{1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234};
    vecs[15] = '{1, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000};

    for (int i = 0; i < N_DUT; i++) begin
      rst[i] = 1'b1;
      drive_idle(i);
      ref_rdata[i] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("reset%0d {stall,done,err}", i), {stall[i], done[i], bus_err[i]}, 3'b000);
      check($sformatf("reset%0d rdata", i), rdata[i], 16'h0000);
    end
    @(posedge clk); #1;

    // Directed table, applied back-to-back with requests held continuously.
    for (int v = 0; v < 16; v++) begin
      access(vecs[v].inst, vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, 1'b0,
             vecs[v].err, vecs[v].exp_rd, $sformatf("vec%0d", v));
    end
    @(negedge clk);
    check("bubble_after_table done", done[1], 1'b0);
    @(posedge clk); #1;

    // Reset abort during WAIT and on the edge that would enter RESP.
    access(2, 1'b0, 1'b1, 16'h0008, 16'h1111, 1'b0, 1'b0, 16'h0000, "pre8");
    reset_abort(2, 16'h0008, 16'h7777, 2, "abort_wait");
    access(2, 1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 1'b0, 16'h1111, "rd8");
    access(2, 1'b0, 1'b1, 16'h0009, 16'h3333, 1'b0, 1'b0, 16'h1111, "pre9");
    reset_abort(2, 16'h0009, 16'h2222, 3, "abort_edge");
    access(2, 1'b1, 1'b0, 16'h0009, 16'h0000, 1'b0, 1'b0, 16'h3333, "rd9");

    // Random accesses against the reference model.
    for (int i = 0; i < N_DUT; i++) begin
      for (int a = 0; a < 16; a++) begin
        logic [15:0] d;
        d = 16'($urandom);
        model(i, 1'b0, 1'b1, 16'(a), d, e, r);
        access(i, 1'b0, 1'b1, 16'(a), d, 1'b0, e, r, $sformatf("fill%0d_%0d", i, a));
      end
      for (int n = 0; n < 40; n++) begin
        int          op;
        int          gap;
        bit          rd, wr;
        logic [15:0] a, d;
        op = $urandom_range(0, 4);
        rd = (op <= 1) || (op == 4);
        wr = (op >= 2);
        a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                         : 16'($urandom_range(0, 15));
        d  = 16'($urandom);
        model(i, rd, wr, a, d, e, r);
        access(i, rd, wr, a, d, 1'($urandom_range(0, 1)), e, r, $sformatf("rnd%0d_%0d", i, n));
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(negedge clk);
          check($sformatf("rnd%0d_%0d idle{stall,done}", i, n), {stall[i], done[i]}, 2'b00);
          @(posedge clk); #1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
